// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one aes_core between N requesters.
// Optional RUN watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_core_arbiter #(
  parameter int N           = 2,
  parameter int K           = 128,
  parameter int LOAD_CYCLES = 3,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*K-1:0]   req_key,
  input  logic [N*128-1:0] req_msg,
  input  logic [N-1:0]     req_dir,
  output logic [N-1:0]     rsp_valid,
  input  logic [N-1:0]     rsp_ready,
  output logic [127:0]     rsp_data,
  output logic             rsp_err,
  output logic             core_ce,
  output logic [K-1:0]     core_key,
  output logic [127:0]     core_msg,
  output logic             core_dir,
  input  logic             core_done,
  input  logic [127:0]     core_out,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for any req_valid; grantee chosen from ptr upward
  // LOAD  | core_ce held high for LOAD_CYCLES cycles; core_done ignored
  // RUN   | core started, waiting for core_done (or watchdog expiry)
  // RESP  | result held on rsp_* until the grantee's rsp_ready

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
    $error("aes_core_arbiter: K must be 128, 192 or 256");
  end
  if (N < 1 || N > 8) begin : g_bad_n
    $error("aes_core_arbiter: N must be 1..8");
  end
  if (LOAD_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_cyc
    $error("aes_core_arbiter: LOAD_CYCLES and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt;
  logic [PW-1:0]   win;
  logic            found;
  logic [N-1:0]    gnt_oh;
  logic [LW-1:0]   load_cnt;
  logic            accept;
  logic            load_last;
  logic            run_hit;
  logic            run_tmo;
  logic            resp_take;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   tmo_cnt;
`endif

  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
  end

  always_comb begin
    gnt_oh      = '0;
    gnt_oh[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_last = 1'b0;
    run_hit   = 1'b0;
    run_tmo   = 1'b0;
    resp_take = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (load_cnt == '0) begin
          load_last = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (core_done) begin
          run_hit   = 1'b1;
          state_nxt = RESP;
        end
`ifdef AES_ARB_TIMEOUT_EN
        else if (tmo_cnt == '0) begin
          run_tmo   = 1'b1;
          state_nxt = RESP;
        end
`endif
      end
      RESP: begin
        if (rsp_ready[gnt]) begin
          resp_take = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = accept && (win == PW'(i));
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      gnt       <= '0;
      load_cnt  <= '0;
      core_ce   <= 1'b0;
      core_key  <= '0;
      core_msg  <= '0;
      core_dir  <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (accept) begin
        gnt      <= win;
        core_key <= req_key[int'(win)*K +: K];
        core_msg <= req_msg[int'(win)*128 +: 128];
        core_dir <= req_dir[win];
        core_ce  <= 1'b1;
        load_cnt <= LW'(LOAD_CYCLES - 1);
      end
      if (state == LOAD) begin
        if (load_last) core_ce  <= 1'b0;
        else           load_cnt <= load_cnt - 1'b1;
      end
      if (run_hit) begin
        rsp_data  <= core_out;
        rsp_valid <= gnt_oh;
      end
      if (run_tmo) begin
        rsp_data  <= '0;
        rsp_valid <= gnt_oh;
      end
      if (resp_take) begin
        rsp_valid <= '0;
        if (gnt == PW'(N - 1)) ptr <= '0;
        else                   ptr <= gnt + 1'b1;
      end
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  // Watchdog reloads on the last LOAD cycle, so RUN lasts at most TIMEOUT+1 cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (load_last) tmo_cnt <= TW'(TIMEOUT);
      else if (state == RUN && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
      if (run_tmo)        rsp_err <= 1'b1;
      else if (resp_take) rsp_err <= 1'b0;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed self-checking bench for aes_core_arbiter (N=2, K=128) with a behavioural core model.
module tb_aes_core_arbiter;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [1:0]   req_valid, req_ready, req_dir, rsp_valid, rsp_ready;
  logic [255:0] req_key, req_msg;
  logic [127:0] rsp_data, core_key, core_msg, core_out;
  logic         rsp_err, core_ce, core_dir, core_done, busy;

  int total = 0;
  int bad   = 0;
  int core_dly;
  bit core_never;

  aes_core_arbiter #(.N(2), .K(128), .LOAD_CYCLES(3), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_msg(req_msg), .req_dir(req_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_ce(core_ce), .core_key(core_key), .core_msg(core_msg), .core_dir(core_dir),
    .core_done(core_done), .core_out(core_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] model_f(input logic [127:0] k, input logic [127:0] m,
                                           input logic d);
    if (k == FIPS_KEY && m == FIPS_PT && !d) return FIPS_CT;
    return k ^ m ^ {128{d}};
  endfunction

  // Core model: starts on ce falling, done after core_dly cycles, done held until next ce.
  logic ce_q, run;
  int   cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_q <= 1'b0; run <= 1'b0; cnt <= 0; core_done <= 1'b0; core_out <= '0;
    end else begin
      ce_q <= core_ce;
      if (core_ce) begin
        core_done <= 1'b0;
        run       <= 1'b0;
      end else if (ce_q) begin
        run <= 1'b1;
        cnt <= core_dly;
      end else if (run && !core_never) begin
        if (cnt <= 1) begin
          core_done <= 1'b1;
          core_out  <= model_f(core_key, core_msg, core_dir);
          run       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input int max);
    int c = 0;
    while (req_ready == 2'b00 && c < max) begin
      @(negedge clk);
      c++;
    end
    chk("wait_req_ready", 128'(req_ready != 2'b00), 128'd1);
  endtask

  task automatic wait_rsp(input int max);
    int c = 0;
    while (rsp_valid == 2'b00 && c < max) begin
      @(negedge clk);
      c++;
    end
    chk("wait_rsp_valid", 128'(rsp_valid != 2'b00), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] exp_d, old_msg;
    int           ce_cnt, cyc;
    logic [1:0]   exp_g;

    req_valid = '0; req_key = '0; req_msg = '0; req_dir = '0; rsp_ready = '0;
    core_dly = 12; core_never = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_core_ce", core_ce, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_msg", core_msg, 0);
    chk("rst_rsp_data", rsp_data, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // single encrypt, FIPS-197 vector
    req_key[127:0] = FIPS_KEY; req_msg[127:0] = FIPS_PT; req_dir = 2'b00;
    req_valid = 2'b01;
    #1 chk("t1_req_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("t1_ready_pulse", req_ready, 0);
    chk("t1_busy", busy, 1);
    chk("t1_core_key", core_key, FIPS_KEY);
    chk("t1_core_msg", core_msg, FIPS_PT);
    ce_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (core_ce) ce_cnt++;
      @(negedge clk);
    end
    chk("t1_ce_cycles", 128'(ce_cnt), 128'd3);
    wait_rsp(40);
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_data", rsp_data, FIPS_CT);
    chk("t1_rsp_err", rsp_err, 0);
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("t1_rsp_drop", rsp_valid, 0);
    chk("t1_idle", busy, 0);
    rsp_ready = 2'b00;

    // reset mid-RUN; pointer is 1 after the first job
    core_dly = 30;
    req_key[255:128] = 128'hdeadbeef_00000000_cafef00d_12345678;
    req_msg[255:128] = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    req_valid = 2'b11;
    #1 chk("rst_rr_ptr1", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (5) @(negedge clk);
    chk("rst_in_run_busy", busy, 1);
    chk("rst_in_run_ce", core_ce, 0);
    reset_n = 1'b0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_ce", core_ce, 0);
    chk("rst_async_rsp_valid", rsp_valid, 0);
    chk("rst_async_core_key", core_key, 0);
    chk("rst_async_core_msg", core_msg, 0);
    chk("rst_async_core_dir", core_dir, 0);
    chk("rst_async_rsp_data", rsp_data, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // contention: both valid, grants must alternate starting at 0
    core_dly = 4; req_dir = 2'b10; rsp_ready = 2'b11; req_valid = 2'b11;
    #1 chk("rst_next_grant0", req_ready, 2'b01);
    for (int j = 0; j < 4; j++) begin
      exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
      wait_rdy(40);
      chk("cont_grant", req_ready, exp_g);
      wait_rsp(60);
      chk("cont_rsp_onehot", rsp_valid, exp_g);
      exp_d = (j % 2 == 0) ? model_f(req_key[127:0], req_msg[127:0], 1'b0)
                           : model_f(req_key[255:128], req_msg[255:128], 1'b1);
      chk("cont_rsp_data", rsp_data, exp_d);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 2'b00;

    // response backpressure, pointer back at 0
    req_key[127:0] = 128'h11112222_33334444_55556666_77778888;
    req_msg[127:0] = 128'ha5a5a5a5_5a5a5a5a_00ff00ff_ff00ff00;
    req_dir = 2'b00;
    exp_d = 128'h11112222_33334444_55556666_77778888 ^ 128'ha5a5a5a5_5a5a5a5a_00ff00ff_ff00ff00;
    req_valid = 2'b11;
    #1 chk("bp_grant", req_ready, 2'b01);
    @(negedge clk);
    wait_rsp(60);
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid_hold", rsp_valid, 2'b01);
      chk("bp_data_hold", rsp_data, exp_d);
      chk("bp_no_grant", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    chk("bp_nongrantee_ready", rsp_valid, 2'b01);
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_rsp_drop", rsp_valid, 0);
    chk("bp_ptr_advance", req_ready, 2'b10);
    req_valid = 2'b00; rsp_ready = 2'b00;
    @(negedge clk);

    // stale done from the previous job while the new job loads; grant wraps 1 -> 0
    core_dly = 5;
    req_key[127:0] = 128'h0123456789abcdef_fedcba9876543210;
    req_msg[127:0] = 128'hffeeddccbbaa9988_7766554433221100;
    req_dir = 2'b01;
    exp_d = 128'h0123456789abcdef_fedcba9876543210 ^ 128'hffeeddccbbaa9988_7766554433221100
            ^ {128{1'b1}};
    req_valid = 2'b01;
    #1 chk("stale_wrap_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    old_msg = req_msg[127:0];
    req_msg[127:0] = ~old_msg;
    #1;
    chk("stale_done_during_load", {core_ce, core_done}, 2'b11);
    chk("stale_latched_msg", core_msg, old_msg);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stale_no_early_rsp", rsp_valid, 0);
    end
    wait_rsp(60);
    chk("stale_rsp_valid", rsp_valid, 2'b01);
    chk("stale_rsp_data", rsp_data, exp_d);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("stale_idle", busy, 0);

`ifdef AES_ARB_TIMEOUT_EN
    // core never finishes: watchdog response 17 cycles after entering RUN
    core_never = 1'b1;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    cyc = 0;
    while (core_ce && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    cyc = 0;
    while (rsp_valid == 2'b00 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo_latency", 128'(cyc), 128'd17);
    chk("tmo_rsp_valid", rsp_valid, 2'b01);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_data", rsp_data, 0);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("tmo_err_clear", rsp_err, 0);
    core_never = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
